uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx.
- Recovers bytes from the asynchronous serial line `rx` using mid-bit sampling driven by a bit-period counter.
- Presents each byte with a one-cycle `valid` strobe.
- Sits between the board RX pin and the user logic (loopback/echo designs with uart_tx at the same baud).

---
 rtl/uart_rx_if.sv | 19 +
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx: recovered byte, strobe and status flags.
// UART_RX_PARITY_EN adds the parity_err strobe.
interface uart_rx_if;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

`ifdef UART_RX_PARITY_EN
   modport master (output data, valid, busy, frame_err, parity_err);
   modport slave  (input  data, valid, busy, frame_err, parity_err);
`else
   modport master (output data, valid, busy, frame_err);
   modport slave  (input  data, valid, busy, frame_err);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling from a bit-period counter.
// Define UART_RX_PARITY_EN to expect one even-parity bit after data bit 7.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 435,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   uart_rx_if.master  out_if
);

   localparam logic [8:0] LastCnt = 9'(CLKS_PER_BIT - 1);
   localparam logic [8:0] HalfCnt = 9'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      StIdle, StStart, StData, StParity, StStop, StBreak
   } state_e;

   state_e     state_q, state_d;
   logic [8:0] cnt_q, cnt_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       ferr_q, ferr_d;
   logic       rx_s1_q, rx_s2_q;
`ifdef UART_RX_PARITY_EN
   logic       par_bit_q, par_bit_d;
   logic       perr_q, perr_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 9'd1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      busy_d    = busy_q;
      ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
      par_bit_d = par_bit_q;
      perr_d    = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            cnt_d  = '0;
            busy_d = 1'b0;
            if (!rx_s2_q) begin
               state_d = StStart;
               busy_d  = 1'b1;
            end
         end
         StStart: begin
            if (cnt_q == HalfCnt) begin
               cnt_d = '0;
               if (!rx_s2_q) begin
                  state_d   = StData;
                  bit_idx_d = '0;
               end else begin
                  // Line already back high at mid start bit: a glitch, not a frame.
                  state_d = StIdle;
                  busy_d  = 1'b0;
               end
            end
         end
         StData: begin
            if (cnt_q == LastCnt) begin
               cnt_d     = '0;
               shift_d   = {rx_s2_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (cnt_q == LastCnt) begin
               cnt_d     = '0;
               par_bit_d = rx_s2_q;
               state_d   = StStop;
            end
         end
`endif
         StStop: begin
            if (cnt_q == LastCnt) begin
               cnt_d = '0;
               if (rx_s2_q) begin
                  ferr_d  = 1'b0;
                  state_d = StIdle;
                  busy_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                  if ((^shift_q) ^ par_bit_q) begin
                     perr_d = 1'b1;
                  end else begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
`else
                  data_d  = shift_q;
                  valid_d = 1'b1;
`endif
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end
            end
         end
         StBreak: begin
            // Hold off start detection until a held-low line releases.
            cnt_d  = '0;
            busy_d = 1'b1;
            if (rx_s2_q) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         ferr_q    <= 1'b0;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
         par_bit_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         ferr_q    <= ferr_d;
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
`ifdef UART_RX_PARITY_EN
         par_bit_q <= par_bit_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign out_if.data      = data_q;
   assign out_if.valid     = valid_q;
   assign out_if.busy      = busy_q;
   assign out_if.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign out_if.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: latency, back-to-back, glitch, break, reset,
// and (with UART_RX_PARITY_EN) parity checking.
module tb_uart_rx;
   localparam int Cpb = 435;
`ifdef UART_RX_PARITY_EN
   localparam int Lat   = 4569;
   localparam int Frame = 11 * Cpb;
`else
   localparam int Lat   = 4134;
   localparam int Frame = 10 * Cpb;
`endif

   logic clk = 1'b0;
   logic rst;
   logic rx;
   uart_rx_if u_if ();

   uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
      .clk    (clk),
      .rst    (rst),
      .rx     (rx),
      .out_if (u_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int vcyc[$];
   logic [7:0] vdata[$];
   int probe_a = -1;
   int probe_b = -1;
   logic busy_a, busy_b, ferr_b;
   int perr_n = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u_if.valid) begin
         vcyc.push_back(cyc);
         vdata.push_back(u_if.data);
      end
      if (cyc == probe_a) busy_a = u_if.busy;
      if (cyc == probe_b) begin
         busy_b = u_if.busy;
         ferr_b = u_if.frame_err;
      end
`ifdef UART_RX_PARITY_EN
      if (u_if.parity_err) perr_n++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic vclear();
      vcyc.delete();
      vdata.delete();
      perr_n = 0;
   endtask

   // Called on a negedge; drives a whole frame, returning the first edge that sees the start bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                             output int e0);
      rx = 1'b0;
      e0 = cyc + 1;
      repeat (Cpb) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Cpb) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^b) ^ par_flip;
      repeat (Cpb) @(negedge clk);
`else
      if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
      rx = stop_b;
      repeat (Cpb) @(negedge clk);
   endtask

   initial begin
      int e0;
      int e0b;
      rst = 1'b0;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", u_if.data, 8'h00);
      check("rst_valid", u_if.valid, 1'b0);
      check("rst_busy", u_if.busy, 1'b0);
      check("rst_ferr", u_if.frame_err, 1'b0);
`ifdef UART_RX_PARITY_EN
      check("rst_perr", u_if.parity_err, 1'b0);
`endif
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // Single frame 0xA5: exact latency and busy window.
      vclear();
      probe_a = cyc + 1 + 3;
      probe_b = cyc + 1 + Lat - 1;
      send_frame(8'hA5, 1'b1, 1'b0, e0);
      check("a5_nvalid", vcyc.size(), 1);
      check("a5_lat", (vcyc.size() > 0) ? vcyc[0] : -1, e0 + Lat);
      check("a5_data", (vdata.size() > 0) ? vdata[0] : 8'hxx, 8'hA5);
      check("a5_ferr", u_if.frame_err, 1'b0);
      check("a5_busy_start", busy_a, 1'b1);
      check("a5_busy_end", busy_b, 1'b1);
      check("a5_busy_idle", u_if.busy, 1'b0);

      // Back-to-back 0x00 then 0xFF with no idle gap.
      vclear();
      send_frame(8'h00, 1'b1, 1'b0, e0);
      send_frame(8'hFF, 1'b1, 1'b0, e0b);
      check("b2b_nvalid", vcyc.size(), 2);
      check("b2b_lat0", (vcyc.size() > 0) ? vcyc[0] : -1, e0 + Lat);
      check("b2b_space", (vcyc.size() > 1) ? vcyc[1] - vcyc[0] : -1, Frame);
      check("b2b_data0", (vdata.size() > 0) ? vdata[0] : 8'hxx, 8'h00);
      check("b2b_data1", (vdata.size() > 1) ? vdata[1] : 8'hxx, 8'hFF);

      // 100-clock low glitch on idle line.
      vclear();
      rx = 1'b0;
      repeat (100) @(negedge clk);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check("gl_busy_mid", u_if.busy, 1'b1);
      repeat (400) @(negedge clk);
      check("gl_nvalid", vcyc.size(), 0);
      check("gl_busy", u_if.busy, 1'b0);
      check("gl_ferr", u_if.frame_err, 1'b0);

      // Bad stop bit, held break, then recovery with 0x5A.
      vclear();
      send_frame(8'h3C, 1'b0, 1'b0, e0);
      repeat (2000) @(negedge clk);
      check("brk_nvalid", vcyc.size(), 0);
      check("brk_ferr", u_if.frame_err, 1'b1);
      check("brk_busy", u_if.busy, 1'b1);
      check("brk_data", u_if.data, 8'hFF);
      rx = 1'b1;
      repeat (50) @(negedge clk);
      check("brk_rel_busy", u_if.busy, 1'b0);
      check("brk_rel_ferr", u_if.frame_err, 1'b1);
      probe_b = cyc + 1 + Lat - 1;
      send_frame(8'h5A, 1'b1, 1'b0, e0);
      check("rec_ferr_before", ferr_b, 1'b1);
      check("rec_nvalid", vcyc.size(), 1);
      check("rec_data", u_if.data, 8'h5A);
      check("rec_ferr", u_if.frame_err, 1'b0);

      // Reset in the middle of bit 4, then a clean 0x81.
      vclear();
      rx = 1'b0;
      repeat (Cpb) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = i[0] ? 1'b0 : 1'b1;
         repeat (Cpb) @(negedge clk);
      end
      rx = 1'b1;
      repeat (200) @(negedge clk);
      check("mid_busy", u_if.busy, 1'b1);
      rst = 1'b0;
      #1;
      check("mr_data", u_if.data, 8'h00);
      check("mr_valid", u_if.valid, 1'b0);
      check("mr_busy", u_if.busy, 1'b0);
      check("mr_ferr", u_if.frame_err, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("mr_nvalid", vcyc.size(), 0);
      send_frame(8'h81, 1'b1, 1'b0, e0);
      check("mr81_nvalid", vcyc.size(), 1);
      check("mr81_data", u_if.data, 8'h81);
      check("mr81_ferr", u_if.frame_err, 1'b0);

`ifdef UART_RX_PARITY_EN
      vclear();
      send_frame(8'h07, 1'b1, 1'b0, e0);
      check("par_good_nvalid", vcyc.size(), 1);
      check("par_good_lat", (vcyc.size() > 0) ? vcyc[0] : -1, e0 + Lat);
      check("par_good_data", u_if.data, 8'h07);
      check("par_good_perr", perr_n, 0);
      vclear();
      send_frame(8'h07, 1'b1, 1'b1, e0);
      check("par_bad_nvalid", vcyc.size(), 0);
      check("par_bad_perr", perr_n, 1);
      check("par_bad_data", u_if.data, 8'h07);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
